// File: rtl/sipo_pkg.sv
// Shared types and defaults for the SIPO shift-register receiver.
// Imported by the bit counter and the receiver top level.
package sipo_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } sipo_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sipo_bit_counter.sv
// Frame bit counter: counts sampled bits 0..WIDTH-1 and flags the last one.
// Clear wins over enable; the count folds back to 0 after the last bit.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     N_clr,
    input  logic                     en,
    input  logic                     clr,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    assign last = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge N_clr) begin
        if (!N_clr) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_shift_receiver.sv
// Serial-in/parallel-out receiver, MSB first, with clock inhibit.
// Holds the IDLE/SHIFT FSM, the shift register and the output word.
module sipo_shift_receiver
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             N_clr,
    input  logic             clk_inh,
    input  logic             start,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    output logic             busy,
    output logic             ser_out
);

    sipo_state_t              state;
    logic [WIDTH-1:0]         sreg;
    logic [WIDTH-1:0]         shifted;
    logic [$clog2(WIDTH)-1:0] cnt;
    logic                     last;
    logic                     run;
    logic                     cnt_en;
    logic                     cnt_clr;
    logic                     unused_cnt;

    assign run     = ~clk_inh;
    assign busy    = (state == SHIFT);
    assign ser_out = sreg[WIDTH-1];
    assign shifted = {sreg[WIDTH-2:0], ser_in};

    // Any enabled start restarts the count: frame start, abort or chain.
    assign cnt_clr    = run & start;
    assign cnt_en     = run & busy;
    assign unused_cnt = ^cnt;

    sipo_bit_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk  (clk),
        .N_clr(N_clr),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .cnt  (cnt),
        .last (last)
    );

    always_ff @(posedge clk or negedge N_clr) begin
        if (!N_clr) begin
            state     <= IDLE;
            sreg      <= '0;
            par_out   <= '0;
            par_valid <= 1'b0;
        end else begin
            par_valid <= 1'b0;
            if (run) begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (last) begin
                            sreg      <= shifted;
                            par_out   <= shifted;
                            par_valid <= 1'b1;
                            if (!start) begin
                                state <= IDLE;
                            end
                        end else if (!start) begin
                            sreg <= shifted;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_shift_receiver.sv
// Scoreboard bench for sipo_shift_receiver: directed frames plus random traffic.
// Expected words, strobe cycles, busy and cascade bits come from a frame-level model.
module tb_sipo_shift_receiver;
    import sipo_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         N_clr = 1'b1;
    logic         clk_inh = 1'b0;
    logic         start = 1'b0;
    logic         ser_in = 1'b0;
    logic [W-1:0] par_out;
    logic         par_valid;
    logic         busy;
    logic         ser_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] w;
        int           c;
    } exp_t;

    exp_t         sb[$];
    bit           hist[$];
    logic [W-1:0] held = '0;
    bit           exp_busy = 1'b0;
    exp_t         mon_e;

    sipo_shift_receiver #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .N_clr    (N_clr),
        .clk_inh  (clk_inh),
        .start    (start),
        .ser_in   (ser_in),
        .par_out  (par_out),
        .par_valid(par_valid),
        .busy     (busy),
        .ser_out  (ser_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, cyc);
        end
    endfunction

    // Cascade output: the bit sampled W enabled samples ago, 0 until then.
    function automatic bit exp_ser();
        if (hist.size() >= W) return hist[hist.size() - W];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (N_clr) begin
            while (sb.size() > 0 && sb[0].c < cyc) begin
                mon_e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL valid_missing: no strobe for word %0h due at cycle %0d",
                         mon_e.w, mon_e.c);
            end
            if (par_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'(par_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("strobe_cycle", cyc, mon_e.c);
                    chk("par_word", 32'(par_out), 32'(mon_e.w));
                    held = mon_e.w;
                end
            end
            chk("par_hold", 32'(par_out), 32'(held));
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("ser_out", 32'(ser_out), 32'(exp_ser()));
        end
    end

    task automatic step(input bit s, input bit b, input bit inh);
        start   = s;
        ser_in  = b;
        clk_inh = inh;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        step(1'b1, bit'($urandom_range(0, 1)), 1'b0);
        exp_busy = 1'b1;
    endtask

    task automatic inhibit(input int n);
        repeat (n) step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, w[W-1-i], 1'b0);
            hist.push_back(w[W-1-i]);
        end
    endtask

    task automatic abort();
        step(1'b1, bit'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input int inh_at,
                              input int inh_n, input bit chain);
        for (int i = 0; i < W; i++) begin
            if (i == inh_at) inhibit(inh_n);
            step(chain && (i == W - 1), w[W-1-i], 1'b0);
            hist.push_back(w[W-1-i]);
            if (i == W - 1) begin
                sb.push_back('{w, cyc});
                if (!chain) exp_busy = 1'b0;
            end
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_par_out", 32'(par_out), 32'd0);
        chk("rst_par_valid", 32'(par_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ser_out", 32'(ser_out), 32'd0);
    endtask

    initial begin
        bit           started;
        bit           chain;
        int           inh_at;
        logic [W-1:0] w;

        #1 N_clr = 1'b0;
        #1 check_reset_outputs();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        N_clr = 1'b1;
        idle(2);

        do_start();
        send_frame(8'hF0, -1, 0, 1'b0);
        idle(2);

        do_start();
        send_frame(8'hAA, 4, 3, 1'b0);
        idle(2);

        do_start();
        send_frame(8'hA5, -1, 0, 1'b1);
        send_frame(8'h3C, -1, 0, 1'b0);
        idle(2);

        do_start();
        send_bits(8'hFF, 5);
        abort();
        send_frame(8'h0F, -1, 0, 1'b0);
        idle(2);

        do_start();
        send_frame(8'hB2, -1, 0, 1'b0);
        idle(2);

        do_start();
        send_bits(8'hE0, 3);
        #2 N_clr = 1'b0;
        #1 check_reset_outputs();
        sb.delete();
        hist.delete();
        held     = '0;
        exp_busy = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        N_clr = 1'b1;
        do_start();
        send_frame(8'h5A, -1, 0, 1'b0);
        idle(2);

        started = 1'b0;
        for (int k = 0; k < 25; k++) begin
            w = W'($urandom);
            if (!started) begin
                do_start();
                if ($urandom_range(0, 3) == 0) begin
                    send_bits(W'($urandom), $urandom_range(1, W - 1));
                    abort();
                end
            end
            inh_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, W - 1) : -1;
            chain  = ($urandom_range(0, 2) == 0) && (k != 24);
            send_frame(w, inh_at, $urandom_range(1, 4), chain);
            started = chain;
            if (!chain) idle($urandom_range(0, 3));
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
        idle(2);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected strobes never seen", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
